// File: rtl/block_move_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : block_move_pkg
//  Brief    : Shared coordinate width and RGB888 colour constants for the
//             HDMI block-move pixel generator.
//  Revision : 1.0 - initial release
// ============================================================================
package block_move_pkg;

    localparam int          COORD_W     = 11;

    localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
    localparam logic [23:0] COLOR_BLACK = 24'h000000;
    localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;

endpackage : block_move_pkg
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_axis
//  Brief    : One-axis position/direction register that steps by STEP on each
//             update strobe and reverses when it reaches MIN or MAX.
//  Revision : 1.0 - initial release
// ============================================================================
module bounce_axis
    import block_move_pkg::*;
#(
    parameter logic [COORD_W-1:0] MIN  = 11'd20,
    parameter logic [COORD_W-1:0] MAX  = 11'd1220,
    parameter logic [COORD_W-1:0] STEP = 11'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_update,
    output logic [COORD_W-1:0] o_pos
);

    // Lower turn point is pre-added so the decrement test never underflows.
    localparam logic [COORD_W-1:0] c_MIN_TURN = MIN + STEP;

    logic [COORD_W-1:0] r_pos;
    logic [COORD_W-1:0] w_pos_nxt;
    logic               r_dir;
    logic               w_dir_nxt;

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (i_update) begin
            if (r_dir) begin
                if (r_pos + STEP >= MAX) begin
                    w_pos_nxt = MAX;
                    w_dir_nxt = 1'b0;
                end else begin
                    w_pos_nxt = r_pos + STEP;
                end
            end else begin
                if (r_pos <= c_MIN_TURN) begin
                    w_pos_nxt = MIN;
                    w_dir_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos - STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= MIN;
            r_dir <= 1'b1;
        end else begin
            r_pos <= w_pos_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    assign o_pos = r_pos;

endmodule : bounce_axis
`default_nettype wire

// File: rtl/block_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : block_move_ctrl
//  Brief    : Pixel generator drawing a white border, blue background and a
//             bouncing black block; block moves only at end of frame.
//  Revision : 1.0 - initial release
// ============================================================================
module block_move_ctrl
    import block_move_pkg::*;
#(
    parameter int H_DISP   = 1280,
    parameter int V_DISP   = 720,
    parameter int BORDER   = 20,
    parameter int BLOCK    = 40,
    parameter int STEP     = 1,
    parameter int MOVE_DIV = 742500
) (
    input  logic               pixel_clk,
    input  logic               sys_rst_n,
    input  logic [COORD_W-1:0] pixel_xpos,
    input  logic [COORD_W-1:0] pixel_ypos,
    output logic [23:0]        pixel_data
);

    localparam int                 c_TICK_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(MOVE_DIV - 1);
    localparam logic [COORD_W-1:0] c_BORDER    = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] c_STEP      = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] c_X_MAX     = COORD_W'(H_DISP - BORDER - BLOCK);
    localparam logic [COORD_W-1:0] c_Y_MAX     = COORD_W'(V_DISP - BORDER - BLOCK);
    localparam logic [COORD_W-1:0] c_H_END     = COORD_W'(H_DISP);
    localparam logic [COORD_W-1:0] c_V_END     = COORD_W'(V_DISP);
    localparam logic [COORD_W-1:0] c_RIGHT     = COORD_W'(H_DISP - BORDER);
    localparam logic [COORD_W-1:0] c_BOTTOM    = COORD_W'(V_DISP - BORDER);
    localparam logic [COORD_W-1:0] c_BLK_M1    = COORD_W'(BLOCK - 1);

    logic [c_TICK_W-1:0] r_tick;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic                r_move_pend;
    logic                w_move_pend_nxt;
    logic                w_tick_wrap;
    logic                w_frame_end;
    logic                w_update;

    logic [COORD_W-1:0]  w_x_pos;
    logic [COORD_W-1:0]  w_y_pos;
    logic [COORD_W-1:0]  w_col;
    logic [COORD_W-1:0]  w_row;
    logic                w_active;
    logic                w_border;
    logic                w_block;
    logic [23:0]         w_pixel_nxt;
    logic [23:0]         r_pixel_data;

    // Move request timing and frame-end gated position update
    always_comb begin
        w_tick_wrap     = (r_tick == c_TICK_LAST);
        w_tick_nxt      = w_tick_wrap ? '0 : r_tick + c_TICK_W'(1);
        w_frame_end     = (pixel_xpos == c_H_END) && (pixel_ypos == c_V_END);
        w_update        = w_frame_end && (r_move_pend || w_tick_wrap);
        w_move_pend_nxt = r_move_pend;
        if (w_update) begin
            w_move_pend_nxt = 1'b0;
        end else if (w_tick_wrap) begin
            w_move_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tick      <= '0;
            r_move_pend <= 1'b0;
        end else begin
            r_tick      <= w_tick_nxt;
            r_move_pend <= w_move_pend_nxt;
        end
    end

    bounce_axis #(
        .MIN  (c_BORDER),
        .MAX  (c_X_MAX),
        .STEP (c_STEP)
    ) u_x_axis (
        .clk      (pixel_clk),
        .rst_n    (sys_rst_n),
        .i_update (w_update),
        .o_pos    (w_x_pos)
    );

    bounce_axis #(
        .MIN  (c_BORDER),
        .MAX  (c_Y_MAX),
        .STEP (c_STEP)
    ) u_y_axis (
        .clk      (pixel_clk),
        .rst_n    (sys_rst_n),
        .i_update (w_update),
        .o_pos    (w_y_pos)
    );

    // Coordinates are 1-based on the request bus; zero means blanking.
    always_comb begin
        w_active = (pixel_xpos != '0) && (pixel_ypos != '0);
        w_col    = pixel_xpos - COORD_W'(1);
        w_row    = pixel_ypos - COORD_W'(1);
        w_border = (w_col < c_BORDER) || (w_col >= c_RIGHT) ||
                   (w_row < c_BORDER) || (w_row >= c_BOTTOM);
        w_block  = (w_col >= w_x_pos) && (w_col <= w_x_pos + c_BLK_M1) &&
                   (w_row >= w_y_pos) && (w_row <= w_y_pos + c_BLK_M1);
        w_pixel_nxt = COLOR_BLACK;
        if (w_active) begin
            if (w_border) begin
                w_pixel_nxt = COLOR_WHITE;
            end else if (w_block) begin
                w_pixel_nxt = COLOR_BLACK;
            end else begin
                w_pixel_nxt = COLOR_BLUE;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pixel_data <= '0;
        end else begin
            r_pixel_data <= w_pixel_nxt;
        end
    end

    assign pixel_data = r_pixel_data;

endmodule : block_move_ctrl
`default_nettype wire

// File: tb/tb_block_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_block_move_ctrl
//  Brief    : Scoreboard bench for block_move_ctrl on a 64x48 test raster.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_block_move_ctrl;
    import block_move_pkg::*;

    localparam int H_DISP   = 64;
    localparam int V_DISP   = 48;
    localparam int DIV      = 10;

    logic        pixel_clk  = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic [10:0] pixel_xpos = '0;
    logic [10:0] pixel_ypos = '0;
    logic [23:0] pixel_data;

    always #5 pixel_clk = ~pixel_clk;

    block_move_ctrl #(
        .H_DISP   (H_DISP),
        .V_DISP   (V_DISP),
        .BORDER   (4),
        .BLOCK    (8),
        .STEP     (3),
        .MOVE_DIV (DIV)
    ) dut (
        .pixel_clk  (pixel_clk),
        .sys_rst_n  (sys_rst_n),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .pixel_data (pixel_data)
    );

    typedef struct {
        bit          chk;
        logic [23:0] exp;
        int          id;
        int          px;
        int          py;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  total  = 0;
    int  bad    = 0;
    int  ncyc   = 0;
    int  req_id = 0;

    // Hand-computed (x,y) after the n-th update from reset, n = 1..23
    int x_tab[1:23] = '{7, 10, 13, 16, 19, 22, 25, 28, 31, 34, 37, 40,
                        43, 46, 49, 52, 49, 46, 43, 40, 37, 34, 31};
    int y_tab[1:23] = '{7, 10, 13, 16, 19, 22, 25, 28, 31, 34, 36, 33,
                        30, 27, 24, 21, 18, 15, 12, 9, 6, 4, 7};

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // One request per cycle; expected output queued for the monitor.
    task automatic drive(input int x, input int y, input bit chk, input logic [23:0] exp);
        sb_t e;
        @(negedge pixel_clk);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        e.chk = chk;
        e.exp = exp;
        e.id  = req_id;
        e.px  = x;
        e.py  = y;
        req_id++;
        sb_q.push_back(e);
        ncyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b1, COLOR_BLACK);
    endtask

    // Next request will see the DUT tick counter at value ph.
    task automatic idle_until(input int ph);
        while ((ncyc % DIV) != ph) drive(0, 0, 1'b1, COLOR_BLACK);
    endtask

    task automatic frame_end();
        drive(H_DISP, V_DISP, 1'b1, COLOR_WHITE);
        @(posedge pixel_clk);
        #2;
    endtask

    task automatic check_pos(input string nm, input int ex, input int ey);
        check({nm, "_x"}, int'(dut.w_x_pos), ex);
        check({nm, "_y"}, int'(dut.w_y_pos), ey);
    endtask

    always @(posedge pixel_clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                total++;
                if (pixel_data !== mon_e.exp) begin
                    bad++;
                    $display("FAIL pixel req%0d (%0d,%0d) got=%h exp=%h",
                             mon_e.id, mon_e.px, mon_e.py, pixel_data, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge pixel_clk);
        #1;
        check("rst_pixel", int'(pixel_data), 0);
        check_pos("rst_pos", 4, 4);
        check("rst_pend", int'(dut.r_move_pend), 0);
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        ncyc      = 1;

        // Classification after reset: border, block, block edge, background, blank
        drive(1, 1, 1'b1, COLOR_WHITE);
        drive(5, 5, 1'b1, COLOR_BLACK);
        drive(12, 12, 1'b1, COLOR_BLACK);
        drive(13, 13, 1'b1, COLOR_BLUE);
        drive(0, 7, 1'b1, COLOR_BLACK);
        drive(7, 0, 1'b1, COLOR_BLACK);
        drive(61, 20, 1'b1, COLOR_WHITE);
        drive(20, 45, 1'b1, COLOR_WHITE);

        // Pending move applied once at frame end; second frame end is a no-op
        idle(12);
        idle_until(5);
        frame_end();
        check_pos("fe1", 7, 7);
        check("fe1_pend", int'(dut.r_move_pend), 0);
        frame_end();
        check_pos("fe2", 7, 7);

        // Many tick periods collapse into a single step
        idle(20 * DIV);
        idle_until(5);
        frame_end();
        check_pos("multi", 10, 10);
        check("multi_pend", int'(dut.r_move_pend), 0);

        // Block now spans col/row 10..17
        drive(10, 10, 1'b1, COLOR_BLUE);
        drive(11, 11, 1'b1, COLOR_BLACK);
        drive(18, 18, 1'b1, COLOR_BLACK);
        drive(19, 19, 1'b1, COLOR_BLUE);
        drive(11, 19, 1'b1, COLOR_BLUE);

        // Bounce sweep: x peaks at 52, y at 36, y returns to 4
        for (int n = 3; n <= 22; n++) begin
            idle_until(3);
            frame_end();
            check_pos($sformatf("sweep%0d", n), x_tab[n], y_tab[n]);
            check($sformatf("sweep%0d_range", n),
                  int'(dut.w_x_pos >= 11'd4 && dut.w_x_pos <= 11'd52 &&
                       dut.w_y_pos >= 11'd4 && dut.w_y_pos <= 11'd36), 1);
        end

        // Tick wrap coincident with frame end
        idle_until(DIV - 1);
        frame_end();
        check_pos("coinc", x_tab[23], y_tab[23]);
        check("coinc_pend", int'(dut.r_move_pend), 0);
        frame_end();
        check_pos("coinc_after", x_tab[23], y_tab[23]);

        // Asynchronous reset mid-scan with a move pending
        idle(12);
        check("pre_rst_pend", int'(dut.r_move_pend), 1);
        drive(1, 1, 1'b1, COLOR_WHITE);
        @(posedge pixel_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_pixel", int'(pixel_data), 0);
        check_pos("arst_pos", 4, 4);
        check("arst_pend", int'(dut.r_move_pend), 0);
        pixel_xpos = '0;
        pixel_ypos = '0;
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        ncyc      = 1;
        drive(1, 1, 1'b1, COLOR_WHITE);
        idle_until(5);
        frame_end();
        check_pos("post_rst", 4, 4);

        idle(2);
        @(posedge pixel_clk);
        #3;
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_block_move_ctrl
`default_nettype wire
